// File: rtl/keypad_pkg.sv
// Shared types for the keypad matrix scanner: key codes, scan candidates and
// the classifier that reduces a full-scan snapshot to a candidate.
package keypad_pkg;

    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        CAND_NONE   = 2'd0,
        CAND_SINGLE = 2'd1,
        CAND_MULTI  = 2'd2
    } cand_kind_t;

    typedef struct packed {
        cand_kind_t kind;
        key_code_t  code;
    } cand_t;

    // Code is forced to 0 for NONE/MULTI so candidates compare by kind alone there.
    function automatic cand_t classify(logic [NUM_KEYS-1:0] pressed);
        cand_t       c;
        int unsigned n;
        n      = 0;
        c.kind = CAND_NONE;
        c.code = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (pressed[i]) begin
                n++;
                c.code = 4'(i);
            end
        end
        if (n == 1) begin
            c.kind = CAND_SINGLE;
        end else if (n > 1) begin
            c.kind = CAND_MULTI;
            c.code = '0;
        end
        return c;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the keypad row lines; resets to the released
// (all-ones) level so nothing looks pressed during reset.
module keypad_row_sync #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: drives one column low at a time, snapshots the rows,
// debounces whole-scan results and reports a single stable key.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter logic [16:0] SCAN_DIV       = 17'd25_000,
    parameter logic [3:0]  DEBOUNCE_SCANS = 4'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_held,
    output logic       key_valid,
    output logic       key_release
);

    logic [NUM_ROWS-1:0] row_sync;

    keypad_row_sync #(
        .WIDTH(NUM_ROWS)
    ) u_row_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (row_n),
        .dout (row_sync)
    );

    logic [16:0]         dwell_q;
    logic [1:0]          col_q;
    logic [NUM_KEYS-1:0] snap_q, snap_d;
    logic                sample, scan_done;
    cand_t               cand, prev_q, prev_d;
    logic [3:0]          deb_cnt_q, deb_cnt_d;
    logic                accept;
    key_code_t           key_code_q, key_code_d;
    logic                key_held_q, key_held_d;
    logic                key_valid_q, key_valid_d;
    logic                key_release_q, key_release_d;

    // Sampling only on the last dwell cycle leaves the earlier ones for line settling.
    assign sample    = (dwell_q == SCAN_DIV - 17'd1);
    assign scan_done = sample && (col_q == 2'd3);
    assign col_n     = ~(4'b0001 << col_q);

    always_comb begin
        snap_d = snap_q;
        if (sample) begin
            for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                snap_d[{2'(r), col_q}] = ~row_sync[r];
            end
        end
    end

    assign cand = classify(snap_d);

    always_comb begin
        deb_cnt_d = deb_cnt_q;
        prev_d    = prev_q;
        if (scan_done) begin
            if (cand == prev_q) begin
                if (deb_cnt_q != DEBOUNCE_SCANS) deb_cnt_d = deb_cnt_q + 4'd1;
            end else begin
                deb_cnt_d = 4'd1;
                prev_d    = cand;
            end
        end
    end

    assign accept = scan_done && (deb_cnt_d == DEBOUNCE_SCANS);

    // Re-accepting the current stable state is a no-op, which suppresses auto-repeat.
    always_comb begin
        key_valid_d   = accept && (cand.kind == CAND_SINGLE) &&
                        !(key_held_q && (key_code_q == cand.code));
        key_release_d = accept && (cand.kind == CAND_NONE) && key_held_q;
        key_code_d    = key_valid_d ? cand.code : key_code_q;
        key_held_d    = key_held_q;
        if (key_valid_d)   key_held_d = 1'b1;
        if (key_release_d) key_held_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q       <= '0;
            col_q         <= '0;
            snap_q        <= '0;
            deb_cnt_q     <= '0;
            prev_q        <= '{kind: CAND_NONE, code: '0};
            key_code_q    <= '0;
            key_held_q    <= 1'b0;
            key_valid_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            if (sample) begin
                dwell_q <= '0;
                col_q   <= col_q + 2'd1;
            end else begin
                dwell_q <= dwell_q + 17'd1;
            end
            snap_q        <= snap_d;
            deb_cnt_q     <= deb_cnt_d;
            prev_q        <= prev_d;
            key_code_q    <= key_code_d;
            key_held_q    <= key_held_d;
            key_valid_q   <= key_valid_d;
            key_release_q <= key_release_d;
        end
    end

    assign key_code    = key_code_q;
    assign key_held    = key_held_q;
    assign key_valid   = key_valid_q;
    assign key_release = key_release_q;

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Input-side counterpart to the team's multiplexed 7-segment display driver: drives a 4x4 key matrix one column at a time, active-low, and reads the rows back.
- Debounces the scan results and reports a single stable key as a code, plus a one-cycle press strobe.
- Sits between the board's keypad pins and the control FSMs, for example the enable/direction control of the display rotation.

Parameters:
- SCAN_DIV, 17'd25_000: clk cycles per column dwell. Must be >= 4. At 100 MHz this is 250 us per column, 1 ms per full scan.
- DEBOUNCE_SCANS, 4'd8: consecutive identical full-scan results required before the stable state changes. Must be >= 2.

Ports:
- clk  input  1  system clock, 100 MHz
- rst_n  input  1  reset: rst_n, asynchronous, active-low; clock clk
- row_n  input  4  matrix row lines, active-low, externally pulled up, asynchronous to clk
- col_n  output  4  matrix column drive, active-low, exactly one bit low at all times
- key_code  output  4  stable key index = row*4 + col; holds its last value after release
- key_held  output  1  high while a debounced single key is pressed
- key_valid  output  1  one-cycle strobe when a new stable key is accepted
- key_release  output  1  one-cycle strobe when the stable state goes from key to none

Behaviour:
- Reset values:
  - col_n = 4'b1110 (column 0 driven)
  - key_code = 0, key_held = 0, key_valid = 0, key_release = 0
  - dwell counter = 0, column index = 0, scan snapshot = all released
  - debounce count = 0, previous candidate = NONE, stable state = NONE
- Synchronizer: row_n passes through a 2-flop synchronizer before any use.
- Dwell counter:
  - Counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, the synchronized rows are sampled into the snapshot bits of the current column.
  - On the next edge the counter wraps to 0 and the column index advances 0->1->2->3->0. col_n = ~(1 << col).
  - The first 3 dwell cycles of each column are settle time and are never sampled.
- Scan done: asserted internally on the sample cycle of column 3. It uses the snapshot including the column-3 bits being sampled that cycle.
- Candidate classification of a full scan:
  - NONE: no bits pressed.
  - SINGLE(code): exactly one bit pressed, code = row*4 + col.
  - MULTI: two or more bits pressed.
- Debounce on each scan done:
  - If the candidate equals the previous candidate (kind and code), count = min(count+1, DEBOUNCE_SCANS).
  - Otherwise count = 1 and the previous candidate is replaced by the new one.
- Acceptance, registered one cycle after scan done, when the new count == DEBOUNCE_SCANS:
  - SINGLE(c) and stable != SINGLE(c): key_code <= c, key_held <= 1, key_valid pulses. This covers both a press from NONE and a direct change from key A to key B.
  - NONE and stable is SINGLE: key_held <= 0, key_release pulses, key_code unchanged.
  - MULTI: stable state, key_code and key_held unchanged, no strobes. Ghosting and rollover are ignored.
  - Saturated count with an unchanged candidate produces no repeat strobes, so there is no auto-repeat.
- key_valid and key_release never assert in the same cycle, and are never asserted for more than 1 cycle.
- Latency: a clean press is reported between DEBOUNCE_SCANS and DEBOUNCE_SCANS+1 full scans after the press, plus 3 cycles. Release is reported with the same latency.
- Bounce: any scan whose candidate differs restarts the count at 1. A press that bounces for k scans therefore delays acceptance by k scans.
- Asynchronous reset mid-scan or mid-debounce: all state returns to reset values immediately. A key still held after reset is re-detected from scratch and produces one fresh key_valid.

Decomposition:
- Package keypad_pkg:
  - typedef key_code_t (logic [3:0])
  - enum cand_kind_t {CAND_NONE, CAND_SINGLE, CAND_MULTI}
  - struct cand_t {kind, code}
  - constant NUM_ROWS = 4, NUM_COLS = 4
- Sub-module keypad_row_sync: parameterized-width 2-flop synchronizer with async active-low reset to all-ones, the released level.
- Scan, classification and debounce stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, so 1 scan = 16 cycles):
- Reset, no keys -> col_n cycles 1110,1101,1011,0111 at a 4-cycle dwell; outputs stay 0 for 200 cycles.
- Hold row_n=1101 only while col_n=1011 (row 1, col 2), cleanly -> exactly one key_valid, key_code=6, key_held=1 within 3-4 scans; no further strobes while held; on release, one key_release, key_held=0, key_code stays 6.
- Same press bouncing for the first 2 scans -> acceptance delayed by 2 scans; still a single key_valid.
- Hold keys 6 and 9 together from idle -> no strobes, key_held=0. Then release key 9 -> key_valid with key_code=6.
- Hold key 3, then switch directly to key 12 with no gap -> key_valid for 3, then key_valid for 12, with no key_release between them.
- Assert rst_n=0 for 2 cycles while key 5 is held and accepted -> outputs and col_n at reset values; after release of reset, one new key_valid with key_code=5.
